md_entry_queue: RTL and testbench

Upstream feeder for the order book. Accepts decoded market-data entries from the MDP parser over a valid/ready handshake and filters them against a target security ID. Buffers survivors in a small FIFO and issues them to the order book at most one per ISSUE_GAP cycles as a registered single-cycle `message_ready` pulse. Also marks packet boundaries and counts dropped entries.

---
 rtl/md_pkg.sv | 20 ++
 rtl/md_sync_fifo.sv | 37 +++
 rtl/md_entry_queue.sv | 91 +++++++++
 tb/tb_md_entry_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared types for the market-data entry queue.
package md_pkg;
  typedef enum logic [1:0] {ACT_NEW = 2'd0, ACT_CHANGE = 2'd1, ACT_DELETE = 2'd2} md_action_e;
  typedef enum logic [1:0] {ENTRY_BID = 2'd0, ENTRY_ASK = 2'd1} md_entry_type_e;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} issue_state_e;
  typedef struct packed {
    logic [7:0]  num_orders;
    logic [15:0] quantity;
    logic [63:0] price;
    logic [1:0]  action;
    logic [1:0]  entry_type;
    logic [31:0] security_id;
    logic        last;
    logic        book;
  } md_entry_t;
  function automatic logic is_book(input logic [31:0] id, input logic [31:0] target,
                                   input logic [1:0] action, input logic [1:0] entry_type);
    return id == target && action <= ACT_DELETE && entry_type <= ENTRY_ASK;
  endfunction
endpackage

// File: rtl/md_sync_fifo.sv
// md_sync_fifo: single-clock FIFO of md_entry_t with full/empty/count.
module md_sync_fifo
  import md_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  md_entry_t              din,
  output md_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  md_entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr, rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rptr];
  always_ff @(posedge clk) if (wr) mem[wptr] <= din;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/md_entry_queue.sv
// md_entry_queue: filters parser entries by security ID, buffers them and
// issues them to the order book at most once per ISSUE_GAP cycles.
module md_entry_queue
  import md_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ISSUE_GAP = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] target_security_id,
  input  logic        issue_enable,
  input  logic        entry_valid,
  output logic        entry_ready,
  input  logic [7:0]  entry_num_orders,
  input  logic [15:0] entry_quantity,
  input  logic [63:0] entry_price,
  input  logic [1:0]  entry_action,
  input  logic [1:0]  entry_type,
  input  logic [31:0] entry_security_id,
  input  logic        entry_last,
  output logic        message_ready,
  output logic        enable_order_book,
  output logic [7:0]  NUM_ORDERS,
  output logic [15:0] QUANTITY,
  output logic [63:0] PRICE,
  output logic [1:0]  ACTION,
  output logic [1:0]  ENTRY_TYPE,
  output logic [31:0] SECURITY_ID,
  output logic        packet_done,
  output logic [15:0] drop_count
);
  localparam int GW = ISSUE_GAP > 2 ? $clog2(ISSUE_GAP) : 1;
  issue_state_e state, state_nx;
  logic [GW-1:0] gcnt;
  logic rdy, full, empty, book, accept, push, pop, idle_like;
  logic [$clog2(DEPTH):0] fifo_count_unused;
  md_entry_t in_e, head;
  assign book = is_book(entry_security_id, target_security_id, entry_action, entry_type);
  assign in_e = {entry_num_orders, entry_quantity, entry_price, entry_action, entry_type,
                 entry_security_id, entry_last, book};
  assign entry_ready = rdy && !full;
  assign accept = entry_valid && entry_ready;
  assign push = accept && (book || entry_last);
  assign enable_order_book = message_ready;
  md_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .din(in_e), .dout(head),
    .full(full), .empty(empty), .count(fifo_count_unused)
  );
  // The last cycle of an ISSUE/GAP run acts as IDLE so slots land exactly ISSUE_GAP apart.
  assign idle_like = state == S_IDLE || (state == S_ISSUE && ISSUE_GAP == 1) ||
                     (state == S_GAP && gcnt == '0);
  assign pop = idle_like && !empty && issue_enable;
  always_comb begin
    state_nx = pop ? S_ISSUE : (state == S_ISSUE && ISSUE_GAP > 1) ? S_GAP :
               idle_like ? S_IDLE : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) gcnt <= '0;
    else if (state == S_ISSUE) gcnt <= GW'(ISSUE_GAP - 2);
    else if (state == S_GAP && gcnt != '0) gcnt <= gcnt - 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rdy           <= 1'b0;
      message_ready <= 1'b0;
      packet_done   <= 1'b0;
      drop_count    <= '0;
      NUM_ORDERS    <= '0;
      QUANTITY      <= '0;
      PRICE         <= '0;
      ACTION        <= '0;
      ENTRY_TYPE    <= '0;
      SECURITY_ID   <= '0;
    end else begin
      rdy           <= 1'b1;
      message_ready <= pop && head.book;
      packet_done   <= pop && head.last;
      if (accept && !book && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      if (pop && head.book) begin
        NUM_ORDERS  <= head.num_orders;
        QUANTITY    <= head.quantity;
        PRICE       <= head.price;
        ACTION      <= head.action;
        ENTRY_TYPE  <= head.entry_type;
        SECURITY_ID <= head.security_id;
      end
    end
endmodule

// File: tb/tb_md_entry_queue.sv
// tb_md_entry_queue: directed vector bench; one instance back-to-back, one with ISSUE_GAP=3.
module tb_md_entry_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, issue_enable, entry_valid, entry_last;
  logic [31:0] tgt, entry_security_id;
  logic [7:0] entry_num_orders;
  logic [15:0] entry_quantity;
  logic [63:0] entry_price;
  logic [1:0] entry_action, entry_type;
  logic rdy_a, mr_a, eob_a, pd_a, rdy_b, mr_b, eob_b, pd_b;
  logic [7:0] no_a, no_b;
  logic [15:0] qty_a, qty_b, drop_a, drop_b;
  logic [63:0] price_a, price_b;
  logic [1:0] act_a, act_b, typ_a, typ_b;
  logic [31:0] sid_a, sid_b;
  int total = 0, bad = 0;

  md_entry_queue #(.DEPTH(8), .ISSUE_GAP(1)) u_a (
    .clk(clk), .reset_n(reset_n), .target_security_id(tgt), .issue_enable(issue_enable),
    .entry_valid(entry_valid), .entry_ready(rdy_a), .entry_num_orders(entry_num_orders),
    .entry_quantity(entry_quantity), .entry_price(entry_price), .entry_action(entry_action),
    .entry_type(entry_type), .entry_security_id(entry_security_id), .entry_last(entry_last),
    .message_ready(mr_a), .enable_order_book(eob_a), .NUM_ORDERS(no_a), .QUANTITY(qty_a),
    .PRICE(price_a), .ACTION(act_a), .ENTRY_TYPE(typ_a), .SECURITY_ID(sid_a),
    .packet_done(pd_a), .drop_count(drop_a)
  );
  md_entry_queue #(.DEPTH(8), .ISSUE_GAP(3)) u_b (
    .clk(clk), .reset_n(reset_n), .target_security_id(tgt), .issue_enable(issue_enable),
    .entry_valid(entry_valid), .entry_ready(rdy_b), .entry_num_orders(entry_num_orders),
    .entry_quantity(entry_quantity), .entry_price(entry_price), .entry_action(entry_action),
    .entry_type(entry_type), .entry_security_id(entry_security_id), .entry_last(entry_last),
    .message_ready(mr_b), .enable_order_book(eob_b), .NUM_ORDERS(no_b), .QUANTITY(qty_b),
    .PRICE(price_b), .ACTION(act_b), .ENTRY_TYPE(typ_b), .SECURITY_ID(sid_b),
    .packet_done(pd_b), .drop_count(drop_b)
  );

  typedef struct {
    logic v;
    logic [31:0] id;
    logic [1:0] act, typ;
    logic [63:0] price;
    logic last;
    logic mr, pd;
    logic [15:0] drop;
    logic [63:0] eprice;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] id, input logic [1:0] act,
                       input logic [1:0] typ, input logic [63:0] price, input logic last);
    entry_valid = v;
    entry_security_id = id;
    entry_action = act;
    entry_type = typ;
    entry_price = price;
    entry_last = last;
    entry_num_orders = 8'd1;
    entry_quantity = 16'd4;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h1234, 2'd0, 2'd0, 64'd9,    1'b1, 1'b0, 1'b0, 16'd0, 64'd0};
    tbl[1] = '{1'b0, 32'h0,    2'd0, 2'd0, 64'd0,    1'b0, 1'b1, 1'b1, 16'd0, 64'd9};
    tbl[2] = '{1'b1, 32'h9999, 2'd0, 2'd0, 64'd5,    1'b0, 1'b0, 1'b0, 16'd1, 64'd9};
    tbl[3] = '{1'b1, 32'h9999, 2'd0, 2'd0, 64'd6,    1'b1, 1'b0, 1'b0, 16'd2, 64'd9};
    tbl[4] = '{1'b0, 32'h0,    2'd0, 2'd0, 64'd0,    1'b0, 1'b0, 1'b1, 16'd2, 64'd9};
    tbl[5] = '{1'b1, 32'h1234, 2'd3, 2'd0, 64'd7,    1'b0, 1'b0, 1'b0, 16'd3, 64'd9};
    tbl[6] = '{1'b1, 32'h1234, 2'd0, 2'd2, 64'd8,    1'b0, 1'b0, 1'b0, 16'd4, 64'd9};
    tbl[7] = '{1'b1, 32'h1234, 2'd1, 2'd1, 64'h55,   1'b0, 1'b0, 1'b0, 16'd4, 64'd9};
    tbl[8] = '{1'b0, 32'h0,    2'd0, 2'd0, 64'd0,    1'b0, 1'b1, 1'b0, 16'd4, 64'h55};
    tbl[9] = '{1'b0, 32'h0,    2'd0, 2'd0, 64'd0,    1'b0, 1'b0, 1'b0, 16'd4, 64'h55};
    tgt = 32'h1234;
    issue_enable = 1'b1;
    reset_n = 1'b0;
    drive(1'b1, 32'h1234, 2'd0, 2'd0, 64'd1, 1'b0);
    repeat (3) step();
    chk("rst_ready", 64'(rdy_a), 64'd0);
    chk("rst_ready_b", 64'(rdy_b), 64'd0);
    chk("rst_mr", 64'(mr_a), 64'd0);
    chk("rst_eob", 64'(eob_a), 64'd0);
    chk("rst_pd", 64'(pd_a), 64'd0);
    chk("rst_price", price_a, 64'd0);
    chk("rst_drop", 64'(drop_a), 64'd0);
    reset_n = 1'b1;
    entry_valid = 1'b0;
    step();
    chk("ready_after_rst", 64'(rdy_a), 64'd1);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].id, tbl[i].act, tbl[i].typ, tbl[i].price, tbl[i].last);
      step();
      chk($sformatf("vec%0d_mr", i), 64'(mr_a), 64'(tbl[i].mr));
      chk($sformatf("vec%0d_eob", i), 64'(eob_a), 64'(tbl[i].mr));
      chk($sformatf("vec%0d_pd", i), 64'(pd_a), 64'(tbl[i].pd));
      chk($sformatf("vec%0d_drop", i), 64'(drop_a), 64'(tbl[i].drop));
      chk($sformatf("vec%0d_price", i), price_a, tbl[i].eprice);
    end
    chk("hold_qty", 64'(qty_a), 64'd4);
    chk("hold_orders", 64'(no_a), 64'd1);
    chk("hold_action", 64'(act_a), 64'd1);
    chk("hold_type", 64'(typ_a), 64'd1);
    chk("hold_sid", 64'(sid_a), 64'h1234);

    issue_enable = 1'b0;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'h1234, 2'd0, 2'd0, 64'(i), 1'b0);
      step();
      chk($sformatf("fill%0d_ready", i), 64'(rdy_a), (i < 8) ? 64'd1 : 64'd0);
    end
    drive(1'b1, 32'h1234, 2'd0, 2'd0, 64'd9, 1'b0);
    step();
    chk("full_held", 64'(rdy_a), 64'd0);
    chk("paused_mr", 64'(mr_a), 64'd0);
    issue_enable = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 1) chk("ready_after_pop", 64'(rdy_a), 64'd1);
      if (i == 2) entry_valid = 1'b0;
      chk($sformatf("drain%0d_mr", i), 64'(mr_a), 64'd1);
      chk($sformatf("drain%0d_price", i), price_a, 64'(i));
    end
    step();
    chk("drained_mr", 64'(mr_a), 64'd0);

    issue_enable = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1234, 2'd0, 2'd1, 64'(10 + i), i == 3);
      step();
    end
    entry_valid = 1'b0;
    issue_enable = 1'b1;
    for (int j = 1; j <= 13; j++) begin
      logic e;
      step();
      e = (j == 1 || j == 4 || j == 7 || j == 10);
      chk($sformatf("gap%0d_mr", j), 64'(mr_b), 64'(e));
      if (e) chk($sformatf("gap%0d_price", j), price_b, 64'(10 + (j - 1) / 3));
      if (j == 10) chk("gap_last_pd", 64'(pd_b), 64'd1);
    end

    issue_enable = 1'b0;
    do_reset();
    drive(1'b1, 32'h9999, 2'd0, 2'd0, 64'd77, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h1234, 2'd0, 2'd0, 64'(20 + i), 1'b0);
      step();
    end
    entry_valid = 1'b0;
    chk("midop_drop_pre", 64'(drop_a), 64'd1);
    issue_enable = 1'b1;
    step();
    chk("midop_issue", 64'(mr_a), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midop_abort_mr", 64'(mr_a), 64'd0);
    chk("midop_abort_drop", 64'(drop_a), 64'd0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("post_rst%0d_mr", i), 64'(mr_a), 64'd0);
      chk($sformatf("post_rst%0d_mr_b", i), 64'(mr_b), 64'd0);
    end
    chk("post_rst_drop", 64'(drop_a), 64'd0);
    drive(1'b1, 32'h1234, 2'd0, 2'd0, 64'd99, 1'b1);
    step();
    entry_valid = 1'b0;
    step();
    chk("post_rst_new_mr", 64'(mr_a), 64'd1);
    chk("post_rst_new_price", price_a, 64'd99);
    chk("post_rst_new_pd", 64'(pd_a), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
